ctrl_ajuste_relogio: RTL and testbench

- Time-set controller for the clock chain (seconds → minutes → hours counters).
- Conditions two raw pushbuttons (synchronise, debounce, edge-detect) and runs a mode FSM: RUN / SET_H / SET_M.
- Generates single-cycle increment pulses for the hour and minute counters, with auto-repeat while the button is held.
- Gates the seconds chain, clears seconds when a manual set is committed, and drives the display blink mask.

---
 rtl/ctrl_ajuste_relogio.sv | 169 ++++++++++++++++
 tb/tb_ctrl_ajuste_relogio.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_ajuste_relogio.sv
// Time-set controller: conditions the mode/inc pushbuttons and runs the RUN/SET_H/SET_M FSM
// that drives the increment pulses, the seconds gate and the blink mask.

module ctrl_ajuste_relogio_deb #(
  parameter int DEB_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_press,
  output logic o_held
);
  localparam int DW = $clog2(DEB_CYC + 1);

  logic          r_s1, r_s2, r_deb, r_deb_d, r_press;
  logic [DW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_deb   <= 1'b1;
      r_deb_d <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_btn_n;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      r_press <= r_deb_d & ~r_deb;
      // level accepted only after DEB_CYC consecutive disagreeing samples
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == DW'(DEB_CYC - 1)) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;
  assign o_held  = ~r_deb;
endmodule

module ctrl_ajuste_relogio #(
  parameter int DEB_CYC   = 500000,
  parameter int HOLD_CYC  = 25000000,
  parameter int REP_CYC   = 5000000,
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  output logic       run_en,
  output logic       inc_hora_set,
  output logic       inc_min_set,
  output logic       zera_seg,
  output logic       blink_h,
  output logic       blink_m,
  output logic [1:0] modo
);
  localparam logic [1:0] S_RUN  = 2'b00;
  localparam logic [1:0] S_SETH = 2'b01;
  localparam logic [1:0] S_SETM = 2'b10;
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam int RMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int RW = $clog2(RMAX + 1);

  // index 0 = mode button, 1 = inc button
  logic [1:0] w_btn_n, w_press, w_held;
  assign w_btn_n = {btn_inc_n, btn_mode_n};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    ctrl_ajuste_relogio_deb #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .i_btn_n (w_btn_n[g]),
      .o_press (w_press[g]),
      .o_held  (w_held[g])
    );
  end

  logic [1:0]    r_st, w_nxt;
  logic [TW-1:0] r_to;
  logic [RW-1:0] r_rep_cnt;
  logic          r_ph, r_rep_on, r_rep_hold;
  logic          r_inc_h, r_inc_m, r_zera;
  logic          w_ev_mode, w_ev_inc, w_zera, w_chg, w_first, w_rep_hit, w_pulse;

  assign w_ev_mode = w_press[0];
  assign w_ev_inc  = w_press[1] & ~w_ev_mode;

  always_comb begin
    w_nxt  = r_st;
    w_zera = 1'b0;
    if (w_ev_mode) begin
      case (r_st)
        S_RUN:   w_nxt = S_SETH;
        S_SETH:  w_nxt = S_SETM;
        default: begin
          w_nxt  = S_RUN;
          w_zera = 1'b1;
        end
      endcase
    end else if (r_st != S_RUN && w_press == 2'b00 && tick_1s &&
                 r_to == TW'(TIMEOUT_S - 1)) begin
      w_nxt = S_RUN;
    end
  end

  assign w_chg     = (w_nxt != r_st);
  assign w_first   = w_ev_inc & (r_st != S_RUN);
  assign w_rep_hit = r_rep_on & w_held[1] & ~w_chg &
                     (r_rep_hold ? (r_rep_cnt == RW'(HOLD_CYC - 1))
                                 : (r_rep_cnt == RW'(REP_CYC - 1)));
  assign w_pulse   = w_first | w_rep_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st       <= S_RUN;
      r_to       <= '0;
      r_ph       <= 1'b0;
      r_rep_on   <= 1'b0;
      r_rep_hold <= 1'b0;
      r_rep_cnt  <= '0;
      r_inc_h    <= 1'b0;
      r_inc_m    <= 1'b0;
      r_zera     <= 1'b0;
    end else begin
      r_st    <= w_nxt;
      r_inc_h <= w_pulse & (r_st == S_SETH);
      r_inc_m <= w_pulse & (r_st == S_SETM);
      r_zera  <= w_zera;

      if (w_chg || r_st == S_RUN || w_press != 2'b00) r_to <= '0;
      else if (tick_1s)                                 r_to <= r_to + 1'b1;

      if (w_chg)        r_ph <= 1'b1;
      else if (tick_1s) r_ph <= ~r_ph;

      // repeat pulses do not count as activity, so they leave r_to alone
      if (w_first) begin
        r_rep_on   <= 1'b1;
        r_rep_hold <= 1'b1;
        r_rep_cnt  <= '0;
      end else if (!r_rep_on || !w_held[1] || w_chg) begin
        r_rep_on  <= 1'b0;
        r_rep_cnt <= '0;
      end else if (w_rep_hit) begin
        r_rep_hold <= 1'b0;
        r_rep_cnt  <= '0;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end

  assign run_en       = (r_st == S_RUN);
  assign modo         = r_st;
  assign inc_hora_set = r_inc_h;
  assign inc_min_set  = r_inc_m;
  assign zera_seg     = r_zera;
  assign blink_h      = (r_st == S_SETH) & r_ph;
  assign blink_m      = (r_st == S_SETM) & r_ph;
endmodule

// File: tb/tb_ctrl_ajuste_relogio.sv
// Randomized bench for ctrl_ajuste_relogio against an operation-level model of the set controller.
module tb_ctrl_ajuste_relogio;
  localparam int DEB = 4, HOLD = 20, REP = 8, TO = 3;

  logic clk = 1'b0, rst = 1'b0, tick_1s = 1'b0, btn_mode_n = 1'b1, btn_inc_n = 1'b1;
  logic run_en, inc_hora_set, inc_min_set, zera_seg, blink_h, blink_m;
  logic [1:0] modo;

  ctrl_ajuste_relogio #(.DEB_CYC(DEB), .HOLD_CYC(HOLD), .REP_CYC(REP), .TIMEOUT_S(TO)) dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .btn_mode_n(btn_mode_n), .btn_inc_n(btn_inc_n),
    .run_en(run_en), .inc_hora_set(inc_hora_set), .inc_min_set(inc_min_set),
    .zera_seg(zera_seg), .blink_h(blink_h), .blink_m(blink_m), .modo(modo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed pulse counts and minute pulse timestamps
  int n_h = 0, n_m = 0, n_z = 0, excl = 0;
  int q_min[$];
  always @(negedge clk) if (rst) begin
    if (inc_hora_set) n_h++;
    if (inc_min_set) begin n_m++; q_min.push_back(cyc); end
    if (zera_seg) n_z++;
    if (int'(inc_hora_set) + int'(inc_min_set) + int'(zera_seg) > 1) excl++;
  end

  // model: mode, blink phase, inactivity seconds, expected pulse totals
  int m_st = 0, m_ph = 0, m_to = 0, e_h = 0, e_m = 0, e_z = 0;
  int checks = 0, failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".modo"}, int'(modo), m_st);
    chk({tag, ".run_en"}, int'(run_en), int'(m_st == 0));
    chk({tag, ".blink_h"}, int'(blink_h), int'(m_st == 1 && m_ph == 1));
    chk({tag, ".blink_m"}, int'(blink_m), int'(m_st == 2 && m_ph == 1));
    chk({tag, ".n_hora"}, n_h, e_h);
    chk({tag, ".n_min"}, n_m, e_m);
    chk({tag, ".n_zera"}, n_z, e_z);
  endtask

  task automatic model_mode();
    if (m_st == 2) e_z++;
    m_st = (m_st + 1) % 3;
    m_to = 0;
    m_ph = 1;
  endtask

  // mode press; modo must move DEB+3 cycles after the edge that first samples the raw level
  task automatic op_mode(input int len, input logic both);
    int c0, lat;
    logic [1:0] prev;
    prev = modo; c0 = cyc; lat = -1;
    btn_mode_n = 1'b0;
    if (both) btn_inc_n = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == len) begin btn_mode_n = 1'b1; btn_inc_n = 1'b1; end
      if (lat < 0 && modo != prev) lat = cyc - c0 - 1;
    end
    chk("mode_lat", lat, DEB + 3);
    model_mode();
    cmp_all(both ? "both" : "mode");
  endtask

  task automatic op_inc(input int len);
    btn_inc_n = 1'b0; step(len);
    btn_inc_n = 1'b1; step(DEB + 8);
    if (m_st == 1) e_h++;
    if (m_st == 2) e_m++;
    if (m_st != 0) m_to = 0;
    cmp_all("inc");
  endtask

  task automatic op_glitch(input int which, input int len);
    if (which == 0) btn_mode_n = 1'b0; else btn_inc_n = 1'b0;
    step(len);
    btn_mode_n = 1'b1; btn_inc_n = 1'b1;
    step(DEB + 8);
    cmp_all("glitch");
  endtask

  task automatic op_tick();
    tick_1s = 1'b1; step(1);
    tick_1s = 1'b0; step(2);
    if (m_st != 0) begin
      m_ph ^= 1;
      m_to++;
      if (m_to == TO) begin m_st = 0; m_to = 0; end
    end
    cmp_all("tick");
  endtask

  initial begin
    int c0, h, f, last, nexp, base, bound;
    // reset state
    step(3);
    chk("rst.run_en", int'(run_en), 1);
    chk("rst.modo", int'(modo), 0);
    chk("rst.pulses", int'({inc_hora_set, inc_min_set, zera_seg}), 0);
    chk("rst.blink", int'({blink_h, blink_m}), 0);
    rst = 1'b1;
    step(50);
    cmp_all("idle");

    // basic set sequence with a sub-debounce glitch
    op_mode($urandom_range(DEB + 1, DEB + 8), 1'b0);
    op_glitch(0, DEB - 1);
    op_inc($urandom_range(DEB, DEB + 8));
    op_mode($urandom_range(DEB, DEB + 8), 1'b0);
    op_inc($urandom_range(DEB, DEB + 8));
    op_mode($urandom_range(DEB, DEB + 8), 1'b0);

    // auto-repeat in SET_M: first pulse at F, then F+HOLD, F+HOLD+REP, ...
    op_mode(DEB + 2, 1'b0);
    op_mode(DEB + 2, 1'b0);
    q_min.delete();
    h = $urandom_range(50, 75);
    c0 = cyc;
    btn_inc_n = 1'b0; step(h);
    btn_inc_n = 1'b1; step(DEB + 12);
    f = c0 + DEB + 4;
    last = c0 + h + DEB + 2;  // last edge at which the debounced level is still pressed
    nexp = 1;
    if (f + HOLD <= last) nexp += 1 + (last - f - HOLD) / REP;
    chk("rep.count", q_min.size(), nexp);
    for (int i = 0; i < nexp && i < q_min.size(); i++)
      chk("rep.time", q_min[i] - f, (i == 0) ? 0 : HOLD + (i - 1) * REP);
    e_m += nexp; m_to = 0;
    cmp_all("rep");
    op_mode(DEB + 2, 1'b0);

    // timeout from SET_H, blink 1->0->1 then back to RUN without zera_seg
    op_mode(DEB + 2, 1'b0);
    repeat (TO) op_tick();

    // simultaneous mode+inc press: mode wins
    op_mode(DEB + 2, 1'b0);
    op_mode(DEB + 3, 1'b1);

    // randomized operation mix
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: op_mode($urandom_range(DEB, DEB + 8), 1'b0);
        1: op_inc($urandom_range(DEB, DEB + 8));
        2: op_glitch($urandom_range(0, 1), $urandom_range(1, DEB - 1));
        default: op_tick();
      endcase
    end

    // reset in the middle of auto-repeat
    while (m_st == 0) op_mode(DEB + 2, 1'b0);
    base = n_h + n_m;
    btn_inc_n = 1'b0;
    bound = 0;
    while (n_h + n_m < base + 2 && bound < 80) begin step(1); bound++; end
    chk("rep.before_rst", int'(n_h + n_m >= base + 2), 1);
    step(3);
    #2 rst = 1'b0;
    #1;
    chk("amid.run_en", int'(run_en), 1);
    chk("amid.modo", int'(modo), 0);
    chk("amid.pulses", int'({inc_hora_set, inc_min_set, zera_seg}), 0);
    chk("amid.blink", int'({blink_h, blink_m}), 0);
    btn_inc_n = 1'b1;
    step(4);
    rst = 1'b1;
    step(DEB + 8);
    m_st = 0; m_to = 0; e_h = n_h; e_m = n_m;
    cmp_all("post_rst");

    chk("exclusive", excl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
